// File: rtl/alu_ctrl_issue_pkg.sv
// Shared ALU operation codes and RV32 opcode/funct field constants,
// used by the issue control block and by the ALU itself.
package alu_ctrl_issue_pkg;

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_XOR  = 4'b0001,
        ALU_SLL  = 4'b0010,
        ALU_ADD  = 4'b0011,
        ALU_SUB  = 4'b0100,
        ALU_MUL  = 4'b0101,
        ALU_ADDI = 4'b0110,
        ALU_SRAI = 4'b0111,
        ALU_LW   = 4'b1000,
        ALU_SW   = 4'b1001,
        ALU_BEQ  = 4'b1010
    } alu_op_e;

    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_W   = 3'b010;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_SR  = 3'b101;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_BEQ = 3'b000;

    // funct_i is packed as {funct7, funct3}
    typedef struct packed {
        logic [6:0] funct7;
        logic [2:0] funct3;
    } funct_t;

    // Operations that hold the ALU for more than one cycle
    function automatic logic is_multicycle(input logic [3:0] code);
        return (code == ALU_MUL);
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of RV32 opcode/funct fields into a 4-bit ALU code,
// with a legal flag for combinations this ALU supports.
module alu_op_decode
    import alu_ctrl_issue_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [9:0] funct_i,
    output logic [3:0] code_o,
    output logic       legal_o
);

    funct_t w_funct;

    assign w_funct = funct_i;

    // Opcode/funct lookup; anything unlisted stays illegal with code AND
    always_comb begin
        code_o  = ALU_AND;
        legal_o = 1'b0;
        case (opcode_i)
            OPC_RTYPE: begin
                case ({w_funct.funct7, w_funct.funct3})
                    {F7_BASE,   F3_AND}: begin code_o = ALU_AND; legal_o = 1'b1; end
                    {F7_BASE,   F3_XOR}: begin code_o = ALU_XOR; legal_o = 1'b1; end
                    {F7_BASE,   F3_SLL}: begin code_o = ALU_SLL; legal_o = 1'b1; end
                    {F7_BASE,   F3_ADD}: begin code_o = ALU_ADD; legal_o = 1'b1; end
                    {F7_ALT,    F3_ADD}: begin code_o = ALU_SUB; legal_o = 1'b1; end
                    {F7_MULDIV, F3_ADD}: begin code_o = ALU_MUL; legal_o = 1'b1; end
                    default: begin
                        code_o  = ALU_AND;
                        legal_o = 1'b0;
                    end
                endcase
            end
            OPC_OPIMM: begin
                // ADDI ignores funct7; SRAI needs the arithmetic-shift funct7
                if (w_funct.funct3 == F3_ADD) begin
                    code_o  = ALU_ADDI;
                    legal_o = 1'b1;
                end else if ((w_funct.funct3 == F3_SR) && (w_funct.funct7 == F7_ALT)) begin
                    code_o  = ALU_SRAI;
                    legal_o = 1'b1;
                end else begin
                    code_o  = ALU_AND;
                    legal_o = 1'b0;
                end
            end
            OPC_LOAD: begin
                if (w_funct.funct3 == F3_W) begin
                    code_o  = ALU_LW;
                    legal_o = 1'b1;
                end else begin
                    code_o  = ALU_AND;
                    legal_o = 1'b0;
                end
            end
            OPC_STORE: begin
                if (w_funct.funct3 == F3_W) begin
                    code_o  = ALU_SW;
                    legal_o = 1'b1;
                end else begin
                    code_o  = ALU_AND;
                    legal_o = 1'b0;
                end
            end
            OPC_BRANCH: begin
                if (w_funct.funct3 == F3_BEQ) begin
                    code_o  = ALU_BEQ;
                    legal_o = 1'b1;
                end else begin
                    code_o  = ALU_AND;
                    legal_o = 1'b0;
                end
            end
            default: begin
                code_o  = ALU_AND;
                legal_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_ctrl_issue.sv
// ALU issue control: decodes accepted instructions into a registered ALU
// code and stalls intake while a multi-cycle MUL occupies the EX stage.
module alu_ctrl_issue
    import alu_ctrl_issue_pkg::*;
#(
    parameter int MUL_CYCLES = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       valid_i,
    input  logic [6:0] opcode_i,
    input  logic [9:0] funct_i,
    input  logic       flush_i,
    output logic       ready_o,
    output logic       valid_o,
    output logic [3:0] ALUCtrl_o,
    output logic       busy_o,
    output logic       illegal_o
);

    localparam logic [0:0] S_IDLE     = 1'b0;
    localparam logic [0:0] S_MUL_WAIT = 1'b1;

    // The cycle of valid_o already counts as one MUL cycle, hence the -2
    localparam logic       MUL_MULTI = (MUL_CYCLES > 1);
    localparam logic [3:0] MUL_LOAD  = (MUL_CYCLES > 1) ? 4'(MUL_CYCLES - 2) : 4'd0;

    logic [0:0] r_state;
    logic [3:0] r_cnt;
    logic       r_valid;
    logic       r_illegal;
    logic [3:0] r_alu;

    logic [0:0] w_state_nxt;
    logic [3:0] w_cnt_nxt;
    logic [3:0] w_code;
    logic       w_legal;
    logic       w_accept;
    logic       w_start_mul;

    alu_op_decode u_decode (
        .opcode_i (opcode_i),
        .funct_i  (funct_i),
        .code_o   (w_code),
        .legal_o  (w_legal)
    );

    assign ready_o     = (r_state == S_IDLE);
    assign busy_o      = (r_state == S_MUL_WAIT);
    assign valid_o     = r_valid;
    assign illegal_o   = r_illegal;
    assign ALUCtrl_o   = r_alu;

    assign w_accept    = valid_i & ready_o & ~flush_i;
    assign w_start_mul = w_accept & w_legal & is_multicycle(w_code) & MUL_MULTI;

    // Next-state and occupancy counter; flush collapses straight to IDLE
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (flush_i) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start_mul) begin
                        w_state_nxt = S_MUL_WAIT;
                        w_cnt_nxt   = MUL_LOAD;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = r_cnt;
                    end
                end
                S_MUL_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = 4'd0;
                    end else begin
                        w_state_nxt = S_MUL_WAIT;
                        w_cnt_nxt   = r_cnt - 4'd1;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = 4'd0;
                end
            endcase
        end
    end

    // FSM state and counter registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Issue outputs; the ALU code only moves on a legal acceptance
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid   <= 1'b0;
            r_illegal <= 1'b0;
            r_alu     <= 4'b0000;
        end else if (flush_i) begin
            r_valid   <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_valid   <= w_accept & w_legal;
            r_illegal <= w_accept & ~w_legal;
            if (w_accept & w_legal) begin
                r_alu <= w_code;
            end
        end
    end

endmodule
